trace_commit_monitor: RTL and testbench

- Synthesizable successor to the simulation-only commit tracer; observes fetch-stage pc/inst and reconstructs in-order commit records through a parametrised history delay line.
- Commit records are buffered in a FIFO and drained over a valid/ready stream to a downstream dumper (UART/debug port).
- Adds stall awareness, a commit limit, halt detection, overflow reporting and backpressure, none of which the previous tracer had.

---
 rtl/trace_commit_monitor.sv | 127 ++++++++++++
 tb/tb_trace_commit_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_commit_monitor.sv
// Commit trace monitor: a fetch pc/inst history delay line reconstructs in-order commit records.
// The records are buffered in a first-word-fall-through FIFO and drained over a valid/ready stream.
// The monitor also tracks the commit count, the commit limit, halt detection and dropped records.
module trace_commit_monitor #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       HIST_DEPTH  = 5,
   parameter int unsigned       FIFO_DEPTH  = 8,
   parameter int unsigned       CNT_W       = 16,
   parameter int unsigned       MAX_COMMITS = 5000,
   parameter logic [DATA_W-1:0] INVALID_PC  = '0,
   parameter bit                HALT_EN     = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             pc,
   input  logic [DATA_W-1:0]             inst,
   input  logic                          cpu_stall,
   input  logic                          enable,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_pc,
   output logic [DATA_W-1:0]             out_inst,
   output logic [CNT_W-1:0]              out_index,
   output logic [CNT_W-1:0]              commit_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          done,
   output logic                          halted,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] hist_pc   [HIST_DEPTH];
   logic [DATA_W-1:0] hist_inst [HIST_DEPTH];

   logic [DATA_W-1:0] mem_pc   [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_inst [FIFO_DEPTH];
   logic [CNT_W-1:0]  mem_idx  [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;

   logic cap, commit, full, pop, push;

   // A new fetch pc is captured only when tracing is live and the pc actually moved.
   assign cap    = enable && !cpu_stall && !done && !halted && (pc != hist_pc[0]);
   // The entry one stage short of the end retires on this capture, if it holds a real pc.
   assign commit = cap && (hist_pc[HIST_DEPTH-2] != INVALID_PC);
   assign full   = (level == LVL_W'(FIFO_DEPTH));
   assign pop    = out_valid && out_ready;
   // A full FIFO still accepts a record when the head leaves on the same edge.
   assign push   = commit && (!full || pop);

   // History delay line: shifts one stage per captured pc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            hist_pc[i]   <= INVALID_PC;
            hist_inst[i] <= '0;
         end
      end else if (cap) begin
         for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
            hist_pc[i]   <= hist_pc[i-1];
            hist_inst[i] <= hist_inst[i-1];
         end
         hist_pc[0]   <= pc;
         hist_inst[0] <= inst;
      end
   end

   // FIFO storage; contents need no reset because out_* are masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]   <= hist_pc[HIST_DEPTH-2];
         mem_inst[wr_ptr] <= hist_inst[HIST_DEPTH-2];
         mem_idx[wr_ptr]  <= commit_count;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Commit counter and sticky status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         commit_count <= '0;
         done         <= 1'b0;
         halted       <= 1'b0;
         overflow     <= 1'b0;
      end else if (commit) begin
         commit_count <= commit_count + CNT_W'(1);
         if (commit_count == CNT_W'(MAX_COMMITS - 1)) done <= 1'b1;
         if (HALT_EN && (hist_inst[HIST_DEPTH-2] == '0)) halted <= 1'b1;
         if (!push) overflow <= 1'b1;
      end
   end

   // Head of FIFO presented directly; zero when empty so reset leaves out_* at 0.
   always_comb begin
      out_valid  = (level != '0);
      fifo_level = level;
      out_pc     = '0;
      out_inst   = '0;
      out_index  = '0;
      if (out_valid) begin
         out_pc    = mem_pc[rd_ptr];
         out_inst  = mem_inst[rd_ptr];
         out_index = mem_idx[rd_ptr];
      end
   end

endmodule

// File: tb/tb_trace_commit_monitor.sv
// Directed self-checking bench for trace_commit_monitor: default instance plus a MAX_COMMITS=3 one.
module tb_trace_commit_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, inst;
   logic        cpu_stall, enable, out_ready;
   logic        out_valid, done, halted, overflow;
   logic [31:0] out_pc, out_inst;
   logic [15:0] out_index, commit_count;
   logic [3:0]  fifo_level;

   logic [31:0] pc2, inst2;
   logic        cpu_stall2, enable2, out_ready2;
   logic        out_valid2, done2, halted2, overflow2;
   logic [31:0] out_pc2, out_inst2;
   logic [15:0] out_index2, commit_count2;
   logic [3:0]  fifo_level2;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   trace_commit_monitor dut (
      .clk(clk), .reset(reset), .pc(pc), .inst(inst), .cpu_stall(cpu_stall), .enable(enable),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_index(out_index), .commit_count(commit_count), .fifo_level(fifo_level),
      .done(done), .halted(halted), .overflow(overflow)
   );

   trace_commit_monitor #(.MAX_COMMITS(3)) dut_lim (
      .clk(clk), .reset(reset), .pc(pc2), .inst(inst2), .cpu_stall(cpu_stall2), .enable(enable2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2), .out_inst(out_inst2),
      .out_index(out_index2), .commit_count(commit_count2), .fifo_level(fifo_level2),
      .done(done2), .halted(halted2), .overflow(overflow2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      pc    = 32'h0;
      inst  = 32'h0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0;
      pc = 0; inst = 0; cpu_stall = 0; enable = 0; out_ready = 0;
      pc2 = 0; inst2 = 0; cpu_stall2 = 0; enable2 = 0; out_ready2 = 0;
      step();

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_commit_count", commit_count, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_flags", {done, halted, overflow}, 0);
      check("rst_out_rec", {out_pc, out_inst, out_index}, 0);
      check("rst_lim_count", commit_count2, 0);
      reset = 1'b1;
      step();

      // Commit limit of 3 on the second instance
      enable2 = 1; out_ready2 = 1;
      for (int k = 1; k <= 7; k++) begin
         pc2 = 32'(4 * k); inst2 = pc2 + 32'h100;
         step();
         if (k == 5) check("lim_done_early", done2, 0);
      end
      check("lim_done", done2, 1);
      check("lim_count3", commit_count2, 3);
      check("lim_last_index", out_index2, 2);
      pc2 = 32; step();
      pc2 = 36; step();
      check("lim_count_hold", commit_count2, 3);
      check("lim_drained", out_valid2, 0);
      enable2 = 0;

      // Basic walk: pc 4..40, first record after 5th distinct pc
      enable = 1; out_ready = 1;
      for (int k = 1; k <= 10; k++) begin
         pc = 32'(4 * k); inst = pc + 32'h100;
         step();
         if (k < 5) check("walk_no_rec", out_valid, 0);
         if (k == 5) begin
            check("walk_first_pc", out_pc, 32'h4);
            check("walk_first_inst", out_inst, 32'h104);
            check("walk_first_index", out_index, 0);
         end
      end
      check("walk_count6", commit_count, 6);
      check("walk_level", fifo_level, 1);
      check("walk_last_pc", out_pc, 32'd24);
      check("walk_last_index", out_index, 5);

      // Held pc and stall
      do_reset();
      pc = 4; inst = 32'h104;
      for (int k = 0; k < 10; k++) step();
      check("hold_no_commit", commit_count, 0);
      cpu_stall = 1;
      pc = 8;  inst = 32'h108; step();
      pc = 12; inst = 32'h10c; step(); step();
      cpu_stall = 0;
      pc = 16; inst = 32'h110; step();
      pc = 20; inst = 32'h114; step();
      pc = 24; inst = 32'h118; step();
      check("stall_no_commit", commit_count, 0);
      pc = 28; inst = 32'h11c; step();
      check("stall_count1", commit_count, 1);
      check("stall_rec_pc", out_pc, 32'h4);
      check("stall_rec_index", out_index, 0);

      // Overflow with out_ready low, then drain in order
      do_reset();
      out_ready = 0;
      for (int k = 1; k <= 13; k++) begin
         pc = 32'(4 * k); inst = pc + 32'h100;
         step();
      end
      check("ovf_level", fifo_level, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_count", commit_count, 9);
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         check("ovf_drain_index", out_index, 64'(i));
         check("ovf_drain_pc", out_pc, 64'(4 * (i + 1)));
         step();
      end
      check("ovf_empty", out_valid, 0);
      check("ovf_level0", fifo_level, 0);

      // Full FIFO with simultaneous pop and push
      do_reset();
      out_ready = 0;
      for (int k = 1; k <= 12; k++) begin
         pc = 32'(4 * k); inst = pc + 32'h100;
         step();
      end
      check("full_level", fifo_level, 8);
      check("full_no_ovf", overflow, 0);
      out_ready = 1; pc = 52; inst = 32'h152;
      step();
      check("pp_level", fifo_level, 8);
      check("pp_no_ovf", overflow, 0);
      check("pp_count", commit_count, 9);
      for (int i = 1; i <= 8; i++) begin
         check("pp_drain_index", out_index, 64'(i));
         check("pp_drain_pc", out_pc, 64'(4 * (i + 1)));
         step();
      end
      check("pp_empty", out_valid, 0);

      // Halt on committed zero instruction, then asynchronous reset mid-stream
      do_reset();
      out_ready = 0;
      for (int j = 0; j <= 8; j++) begin
         pc = 32'h0040_0000 + 32'(4 * j);
         inst = (j == 4) ? 32'h0 : pc + 32'h100;
         step();
      end
      check("halt_flag", halted, 1);
      check("halt_count", commit_count, 5);
      check("halt_level", fifo_level, 5);
      pc = 32'h0040_0024; inst = 32'h0040_0124;
      step();
      check("halt_blocks", commit_count, 5);
      out_ready = 1;
      for (int i = 0; i < 4; i++) step();
      out_ready = 0;
      check("halt_rec_pc", out_pc, 32'h0040_0010);
      check("halt_rec_inst", out_inst, 32'h0);
      check("halt_rec_index", out_index, 4);
      check("halt_rec_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_count", commit_count, 0);
      check("async_level", fifo_level, 0);
      check("async_flags", {done, halted, overflow}, 0);
      reset = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
